// File: rtl/alu_op_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states
// and the default operand width.
package alu_op_pkg;

  localparam int WIDTH_DEF = 6;

  localparam logic [3:0] OP_A    = 4'b0001;
  localparam logic [3:0] OP_B    = 4'b0010;
  localparam logic [3:0] OP_NEGA = 4'b0100;
  localparam logic [3:0] OP_NEGB = 4'b0101;
  localparam logic [3:0] OP_NOTA = 4'b1001;
  localparam logic [3:0] OP_NOTB = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb2.sv
// Two-way grant for the ALU arbiter. Fixed priority (requester 0 wins) by
// default; ALU_ARB_ROUND_ROBIN_EN selects alternating priority instead.
module alu_arb2 (
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // prio1 = 1 means requester 1 wins the next tie.
  logic prio1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio1 <= 1'b0;
    else if (grant0 || grant1)
      prio1 <= grant0;
  end

  // NOTE: both grants get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant0 = !prio1;
        grant1 = prio1;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end
`else
  assign grant0 = en && valid0;
  assign grant1 = en && valid1 && !valid0;
`endif

endmodule

// File: rtl/alu_op_arbiter.sv
// Arbitrates two requesters onto one unary ALU: IDLE grants and captures the
// op, EXEC computes and registers the result, RESP holds it until taken.
// Optional macro ALU_ARB_ROUND_ROBIN_EN switches the grant to round-robin.
module alu_op_arbiter
  import alu_op_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_X,
  output logic             res_id,
  output logic             res_err,
  output logic             busy
);

  state_t           state;
  logic [3:0]       cap_sel;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_id;
  logic             grant0;
  logic             grant1;
  logic             arb_en;
  logic [WIDTH-1:0] alu_x;
  logic             alu_err;

  // Gating with rst keeps both readys low while reset is held.
  assign arb_en = (state == ST_IDLE) && !rst;

  alu_arb2 u_arb (
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    alu_x   = '0;
    alu_err = 1'b0;
    case (cap_sel)
      OP_A:    alu_x = cap_a;
      OP_B:    alu_x = cap_b;
      OP_NEGA: alu_x = '0 - cap_a;
      OP_NEGB: alu_x = '0 - cap_b;
      OP_NOTA: alu_x = ~cap_a;
      OP_NOTB: alu_x = ~cap_b;
      default: alu_err = 1'b1;
    endcase
  end

  // NOTE: the capture registers are reset along with the FSM; they are few
  // flops and this keeps simulation free of X on the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cap_sel <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_id  <= 1'b0;
      res_X   <= '0;
      res_id  <= 1'b0;
      res_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            cap_sel <= grant1 ? req1_sel : req0_sel;
            cap_a   <= grant1 ? req1_A   : req0_A;
            cap_b   <= grant1 ? req1_B   : req0_B;
            cap_id  <= grant1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_X   <= alu_x;
          res_id  <= cap_id;
          res_err <= alu_err;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: vector table of single ops plus
// hand-written arbitration, stall and mid-operation reset sequences.
module tb_alu_op_arbiter;
  import alu_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_sel;
  logic [5:0] req0_A, req0_B;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_sel;
  logic [5:0] req1_A, req1_B;
  logic       res_valid, res_ready;
  logic [5:0] res_X;
  logic       res_id, res_err, busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         r;
    logic [3:0] sel;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] x;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  alu_op_arbiter #(.WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_X      (res_X),
    .res_id     (res_id),
    .res_err    (res_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input int r, input logic v, input logic [3:0] s,
                       input logic [5:0] a, input logic [5:0] b);
    if (r == 0) begin
      req0_valid = v; req0_sel = s; req0_A = a; req0_B = b;
    end else begin
      req1_valid = v; req1_sel = s; req1_A = a; req1_B = b;
    end
  endtask

  // One op from a single requester: accept, EXEC, RESP, then drain.
  task automatic run_op(input int idx, input vec_t v);
    logic own_ready, oth_ready;
    @(negedge clk);
    drive(v.r, 1'b1, v.sel, v.a, v.b);
    res_ready = 1'b0;
    #1;
    own_ready = (v.r == 0) ? req0_ready : req1_ready;
    oth_ready = (v.r == 0) ? req1_ready : req0_ready;
    check($sformatf("v%0d_ready", idx), 32'(own_ready), 32'(1));
    check($sformatf("v%0d_other_ready", idx), 32'(oth_ready), 32'(0));
    @(negedge clk);
    drive(v.r, 1'b0, ~v.sel, ~v.a, ~v.b);
    #1;
    check($sformatf("v%0d_exec_valid", idx), 32'(res_valid), 32'(0));
    check($sformatf("v%0d_exec_busy", idx), 32'(busy), 32'(1));
    @(negedge clk);
    #1;
    check($sformatf("v%0d_valid", idx), 32'(res_valid), 32'(1));
    check($sformatf("v%0d_x", idx), 32'(res_X), 32'(v.x));
    check($sformatf("v%0d_id", idx), 32'(res_id), 32'(v.r));
    check($sformatf("v%0d_err", idx), 32'(res_err), 32'(v.err));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check($sformatf("v%0d_drain_valid", idx), 32'(res_valid), 32'(0));
    check($sformatf("v%0d_drain_busy", idx), 32'(busy), 32'(0));
  endtask

  initial begin
    vecs[0]  = '{r: 0, sel: 4'b0100, a: 6'd3,  b: 6'd0,  x: 6'b111101, err: 1'b0};
    vecs[1]  = '{r: 1, sel: 4'b0001, a: 6'd21, b: 6'd50, x: 6'd21,     err: 1'b0};
    vecs[2]  = '{r: 0, sel: 4'b0010, a: 6'd7,  b: 6'd42, x: 6'd42,     err: 1'b0};
    vecs[3]  = '{r: 1, sel: 4'b0100, a: 6'd32, b: 6'd1,  x: 6'd32,     err: 1'b0};
    vecs[4]  = '{r: 0, sel: 4'b0101, a: 6'd9,  b: 6'd0,  x: 6'd0,      err: 1'b0};
    vecs[5]  = '{r: 1, sel: 4'b1010, a: 6'd5,  b: 6'd0,  x: 6'd63,     err: 1'b0};
    vecs[6]  = '{r: 0, sel: 4'b1001, a: 6'd42, b: 6'd0,  x: 6'd21,     err: 1'b0};
    vecs[7]  = '{r: 1, sel: 4'b0111, a: 6'd12, b: 6'd3,  x: 6'd0,      err: 1'b1};
    vecs[8]  = '{r: 0, sel: 4'b0100, a: 6'd0,  b: 6'd7,  x: 6'd0,      err: 1'b0};
    vecs[9]  = '{r: 1, sel: 4'b0101, a: 6'd4,  b: 6'd1,  x: 6'd63,     err: 1'b0};
    vecs[10] = '{r: 0, sel: 4'b0000, a: 6'd5,  b: 6'd5,  x: 6'd0,      err: 1'b1};
    vecs[11] = '{r: 1, sel: 4'b1001, a: 6'd63, b: 6'd2,  x: 6'd0,      err: 1'b0};

    rst = 1'b1;
    res_ready = 1'b0;
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);

    // Reset state, with requests pending so readys are really gated.
    @(negedge clk);
    drive(0, 1'b1, OP_A, 6'd1, 6'd1);
    drive(1, 1'b1, OP_A, 6'd2, 6'd2);
    #1;
    check("rst_valid", 32'(res_valid), 32'(0));
    check("rst_x", 32'(res_X), 32'(0));
    check("rst_id", 32'(res_id), 32'(0));
    check("rst_err", 32'(res_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready0", 32'(req0_ready), 32'(0));
    check("rst_ready1", 32'(req1_ready), 32'(0));
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(i, vecs[i]);

    // Both valid in the same cycle, consumer always ready.
    @(negedge clk);
    drive(0, 1'b1, OP_A, 6'd5, 6'd0);
    drive(1, 1'b1, OP_B, 6'd0, 6'd9);
    res_ready = 1'b1;
    #1;
    check("both_ready0", 32'(req0_ready), 32'(1));
    check("both_ready1", 32'(req1_ready), 32'(0));
    @(negedge clk); #1;
    check("both_exec_ready0", 32'(req0_ready), 32'(0));
    check("both_exec_ready1", 32'(req1_ready), 32'(0));
    @(negedge clk); #1;
    check("both_r1_valid", 32'(res_valid), 32'(1));
    check("both_r1_x", 32'(res_X), 32'(5));
    check("both_r1_id", 32'(res_id), 32'(0));
    @(negedge clk); #1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    check("rr_ready1", 32'(req1_ready), 32'(1));
    check("rr_ready0", 32'(req0_ready), 32'(0));
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);
    @(negedge clk); #1;
    check("rr_r2_valid", 32'(res_valid), 32'(1));
    check("rr_r2_x", 32'(res_X), 32'(9));
    check("rr_r2_id", 32'(res_id), 32'(1));
`else
    check("fix_ready0", 32'(req0_ready), 32'(1));
    check("fix_ready1", 32'(req1_ready), 32'(0));
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    @(negedge clk); #1;
    check("fix_r2_x", 32'(res_X), 32'(5));
    check("fix_r2_id", 32'(res_id), 32'(0));
    @(negedge clk); #1;
    check("fix_r3_ready1", 32'(req1_ready), 32'(1));
    @(negedge clk);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);
    @(negedge clk); #1;
    check("fix_r3_x", 32'(res_X), 32'(9));
    check("fix_r3_id", 32'(res_id), 32'(1));
`endif
    @(negedge clk); #1;
    check("both_end_busy", 32'(busy), 32'(0));
    res_ready = 1'b0;

    // Consumer stalls for 5 cycles while requester 1 waits.
    @(negedge clk);
    drive(0, 1'b1, OP_NOTA, 6'd0, 6'd0);
    #1;
    check("stall_accept", 32'(req0_ready), 32'(1));
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    drive(1, 1'b1, OP_A, 6'd7, 6'd0);
    #1;
    check("stall_exec_ready1", 32'(req1_ready), 32'(0));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d_valid", i), 32'(res_valid), 32'(1));
      check($sformatf("stall%0d_x", i), 32'(res_X), 32'(63));
      check($sformatf("stall%0d_id", i), 32'(res_id), 32'(0));
      check($sformatf("stall%0d_readys", i), 32'({req0_ready, req1_ready}), 32'(0));
      check($sformatf("stall%0d_busy", i), 32'(busy), 32'(1));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("stall_after_valid", 32'(res_valid), 32'(0));
    check("stall_after_ready1", 32'(req1_ready), 32'(1));
    @(negedge clk);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);
    @(negedge clk); #1;
    check("stall_r2_x", 32'(res_X), 32'(7));
    check("stall_r2_id", 32'(res_id), 32'(1));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset while an op from requester 0 sits in EXEC.
    @(negedge clk);
    drive(0, 1'b1, OP_A, 6'd33, 6'd0);
    #1;
    check("mrst_accept", 32'(req0_ready), 32'(1));
    @(negedge clk);
    drive(0, 1'b1, OP_B, 6'd0, 6'd11);
    drive(1, 1'b1, OP_A, 6'd44, 6'd0);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(res_valid), 32'(0));
    check("mrst_x", 32'(res_X), 32'(0));
    check("mrst_id", 32'(res_id), 32'(0));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_readys", 32'({req0_ready, req1_ready}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_grant0", 32'(req0_ready), 32'(1));
    check("mrst_grant1", 32'(req1_ready), 32'(0));
    check("mrst_no_result", 32'(res_valid), 32'(0));
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 6'd0, 6'd0);
    drive(1, 1'b0, 4'd0, 6'd0, 6'd0);
    #1;
    check("mrst_exec_valid", 32'(res_valid), 32'(0));
    @(negedge clk); #1;
    check("mrst_r_valid", 32'(res_valid), 32'(1));
    check("mrst_r_x", 32'(res_X), 32'(11));
    check("mrst_r_id", 32'(res_id), 32'(0));
    res_ready = 1'b1;
    @(negedge clk); #1;
    check("mrst_end_busy", 32'(busy), 32'(0));
    // res_ready held high in IDLE must not produce anything.
    @(negedge clk); #1;
    check("idle_ready_ignored", 32'(res_valid), 32'(0));
    res_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_op_arbiter.md
ALU_OP_ARBITER -- requirements
Module: alu_op_arbiter

Interface
REQ-001 Parameter: WIDTH, 6, operand/result width in bits.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_sel  input  4  requester 0 op code.
REQ-007 Port: req0_A / req0_B  input  WIDTH each  requester 0 operands.
REQ-008 Port: req1_valid, req1_ready, req1_sel, req1_A, req1_B  same as REQ-004..007 for requester 1.
REQ-009 Port: res_valid  output  1  result held on res_X.
REQ-010 Port: res_ready  input  1  consumer takes result.
REQ-011 Port: res_X  output  WIDTH  result value.
REQ-012 Port: res_id  output  1  requester that owns the result.
REQ-013 Port: res_err  output  1  op code was unsupported.
REQ-014 Port: busy  output  1  FSM not in IDLE.

Function
REQ-015 Op codes: 0001 X=A; 0010 X=B; 0100 X=-A; 0101 X=-B; 1001 X=~A; 1010 X=~B; all arithmetic modulo 2^WIDTH.
REQ-016 FSM states IDLE, EXEC, RESP; IDLE->EXEC on grant; EXEC->RESP unconditionally; RESP->IDLE when res_ready=1.
REQ-017 In IDLE with any reqN_valid=1, arbiter grants one requester; reqN_ready=1 combinationally for the granted requester only, in that cycle only.
REQ-018 readys are 0 in EXEC and RESP; requests stay pending (valid held by requester) until accepted.
REQ-019 On accept, sel/A/B and requester id are captured into internal registers; later input changes have no effect on the in-flight op.
REQ-020 EXEC computes the result from captured operands and registers res_X, res_id, res_err; res_valid=1 from the cycle after EXEC.
REQ-021 Latency: accept in cycle N -> res_valid=1 in cycle N+2; minimum issue interval 3 cycles.
REQ-022 res_X, res_id, res_err stable while res_valid=1 and res_ready=0.
REQ-023 res_ready=1 in RESP: res_valid drops next cycle; a new grant possible in that next cycle (IDLE).
REQ-024 Unsupported op code: res_X=0, res_err=1, still completes normally; otherwise res_err=0.
REQ-025 Negation boundaries: -0 = 0; -(100000b) = 100000b (no saturation, no flag).
REQ-026 res_ready when res_valid=0 is ignored.

Reset
REQ-027 rst=1 forces immediately: state IDLE, res_valid=0, res_X=0, res_id=0, res_err=0, busy=0, both readys 0, priority pointer to requester 0.
REQ-028 Reset mid-operation discards the in-flight op; no result is ever produced for it.
REQ-029 First grant after reset with both requesters valid goes to requester 0.

Configuration
REQ-030 Macro ALU_ARB_ROUND_ROBIN_EN defined: both valid -> grant the requester not granted last; pointer updates on each accept.
REQ-031 Macro not defined: fixed priority, requester 0 always wins when both valid; no pointer register.

Structure
REQ-032 Shared package alu_op_pkg holds op-code constants (OP_A, OP_B, OP_NEGA, OP_NEGB, OP_NOTA, OP_NOTB), FSM state typedef, default WIDTH.
REQ-033 One sub-module alu_arb2 implements the two-way grant (fixed or round-robin); FSM and operand datapath stay in top.

Verification
REQ-034 Reset, req0 valid sel=0100 A=000011 -> req0_ready in cycle N, res_valid at N+2, res_X=111101, res_id=0, res_err=0.
REQ-035 Both valid same cycle, sel=0001 A=5 / sel=0010 B=9, res_ready=1 -> results 5 (id 0) then 9 (id 1); without macro, req0 held valid -> id 0 twice.
REQ-036 sel=0111 A=12 -> res_X=0, res_err=1, FSM returns to IDLE after res_ready.
REQ-037 res_ready=0 for 5 cycles in RESP -> res_X/res_id stable, both readys 0, busy=1 throughout.
REQ-038 sel=0100 A=100000 -> 100000; sel=0101 B=0 -> 0; sel=1010 B=000000 -> 111111.
REQ-039 rst asserted in EXEC -> outputs zero same cycle, no res_valid afterwards, next grant with both valid goes to req0.
